// File: rtl/mc_pkg.sv
// mc_pkg -- shared encodings for the multi-cycle MIPS-subset controller.
// Holds the FSM state enum, ALU operation codes, opcode/funct constants,
// datapath select encodings and the instruction class produced by the
// decoder.
// Optional feature: MC_CTRL_JUMP_EN makes jal and jr legal instructions.
package mc_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    // ALU select
    localparam logic [2:0] ZERO_OP = 3'b000;
    localparam logic [2:0] ADD_OP  = 3'b001;
    localparam logic [2:0] SUB_OP  = 3'b010;
    localparam logic [2:0] ORR_OP  = 3'b011;

    // Opcodes IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Funct codes IR[5:0] for R-type
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;

    // Immediate extension select
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    // Next-PC select
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    // Destination register select
    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    // Write-data select
    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    // Instruction classes; anything unrecognised becomes CL_NOP.
    typedef enum logic [3:0] {
        CL_NOP  = 4'd0,
        CL_ADDU = 4'd1,
        CL_SUBU = 4'd2,
        CL_ORI  = 4'd3,
        CL_LUI  = 4'd4,
        CL_LW   = 4'd5,
        CL_SW   = 4'd6,
        CL_BEQ  = 4'd7,
        CL_J    = 4'd8,
        CL_JAL  = 4'd9,
        CL_JR   = 4'd10
    } iclass_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode -- combinational opcode/funct to instruction-class decoder.
// Ports:
//   op     in  6  IR[31:26]
//   funct  in  6  IR[5:0]
//   iclass out    decoded instruction class (CL_NOP for anything undefined)
// Optional feature: MC_CTRL_JUMP_EN enables decoding of jal and jr; without
// it both fall through to CL_NOP.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    iclass
);

    always_comb begin
        iclass = CL_NOP;
        unique case (op)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADDU: iclass = CL_ADDU;
                    FN_SUBU: iclass = CL_SUBU;
`ifdef MC_CTRL_JUMP_EN
                    FN_JR:   iclass = CL_JR;
`endif
                    default: iclass = CL_NOP;
                endcase
            end
            OP_ORI:  iclass = CL_ORI;
            OP_LUI:  iclass = CL_LUI;
            OP_LW:   iclass = CL_LW;
            OP_SW:   iclass = CL_SW;
            OP_BEQ:  iclass = CL_BEQ;
            OP_J:    iclass = CL_J;
`ifdef MC_CTRL_JUMP_EN
            OP_JAL:  iclass = CL_JAL;
`endif
            default: iclass = CL_NOP;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl -- multi-cycle controller FSM for a small MIPS subset
// (addu, subu, ori, lui, lw, sw, beq, j; jal/jr optional).
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   op, funct, zero      instruction fields and branch equality flag
//   alu_op, alu_src_b, ext_op              ALU controls
//   ir_write, pc_write, mem_write, reg_write  write strobes
//   pc_src, reg_dst, wd_sel                datapath selects
//   state                current FSM state (debug)
// Optional feature: define MC_CTRL_JUMP_EN to make jal and jr legal.
// All outputs are Moore-style decodes of (state, instruction class); only
// the beq branch strobe also looks at zero.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_op,
    output logic       alu_src_b,
    output logic [1:0] ext_op,
    output logic       ir_write,
    output logic       pc_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic [2:0] state
);

    state_t  state_reg;
    state_t  state_next;
    iclass_t iclass;

    mc_ctrl_decode u_decode (
        .op     (op),
        .funct  (funct),
        .iclass (iclass)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = S_FETCH;
        unique case (state_reg)
            S_RESET:  state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                // Single-cycle jumps and no-ops return straight to fetch.
                unique case (iclass)
                    CL_NOP, CL_J, CL_JAL, CL_JR: state_next = S_FETCH;
                    default:                     state_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                unique case (iclass)
                    CL_LW, CL_SW:                   state_next = S_MEM;
                    CL_ADDU, CL_SUBU, CL_ORI, CL_LUI: state_next = S_WB;
                    default:                        state_next = S_FETCH;
                endcase
            end
            S_MEM:    state_next = (iclass == CL_LW) ? S_WB : S_FETCH;
            S_WB:     state_next = S_FETCH;
            default:  state_next = S_RESET;
        endcase
    end

    // Output decode
    always_comb begin
        alu_op    = ZERO_OP;
        alu_src_b = 1'b0;
        ext_op    = EXT_ZERO;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        pc_src    = PC_PLUS4;
        reg_dst   = DST_RT;
        wd_sel    = WD_ALU;
        unique case (state_reg)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                pc_src   = PC_PLUS4;
            end
            S_DECODE: begin
                unique case (iclass)
                    CL_J: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                    end
                    CL_JAL: begin
                        // Link and jump in one cycle: $31 <= PC+4.
                        pc_write  = 1'b1;
                        pc_src    = PC_JUMP;
                        reg_write = 1'b1;
                        reg_dst   = DST_RA;
                        wd_sel    = WD_PC4;
                    end
                    CL_JR: begin
                        pc_write = 1'b1;
                        pc_src   = PC_RS;
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                unique case (iclass)
                    CL_ADDU: alu_op = ADD_OP;
                    CL_SUBU: alu_op = SUB_OP;
                    CL_ORI: begin
                        alu_op    = ORR_OP;
                        alu_src_b = 1'b1;
                        ext_op    = EXT_ZERO;
                    end
                    CL_LUI: begin
                        // rs reads $0, so OR with the shifted immediate
                        // yields imm << 16.
                        alu_op    = ORR_OP;
                        alu_src_b = 1'b1;
                        ext_op    = EXT_LUI;
                    end
                    CL_LW, CL_SW: begin
                        alu_op    = ADD_OP;
                        alu_src_b = 1'b1;
                        ext_op    = EXT_SIGN;
                    end
                    CL_BEQ: begin
                        alu_op   = SUB_OP;
                        pc_write = zero;
                        pc_src   = PC_BRANCH;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_write = (iclass == CL_SW);
            end
            S_WB: begin
                unique case (iclass)
                    CL_ADDU, CL_SUBU: begin
                        reg_write = 1'b1;
                        reg_dst   = DST_RD;
                        wd_sel    = WD_ALU;
                    end
                    CL_ORI, CL_LUI: begin
                        reg_write = 1'b1;
                        reg_dst   = DST_RT;
                        wd_sel    = WD_ALU;
                    end
                    CL_LW: begin
                        reg_write = 1'b1;
                        reg_dst   = DST_RT;
                        wd_sel    = WD_MEM;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign state = state_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl -- self-checking bench for mc_ctrl. Expected per-cycle output
// vectors are queued when an instruction is presented and popped/compared
// once per cycle, one line printed per instruction.
module tb_mc_ctrl;
    import mc_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alu_op;
    logic       alu_src_b;
    logic [1:0] ext_op;
    logic       ir_write;
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    mc_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .alu_op    (alu_op),
        .alu_src_b (alu_src_b),
        .ext_op    (ext_op),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .mem_write (mem_write),
        .reg_write (reg_write),
        .pc_src    (pc_src),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, alu_op, alu_src_b, ext_op, ir_w, pc_w, mem_w, reg_w, pc_src, reg_dst, wd_sel}
    typedef struct {
        logic [18:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];

    function automatic logic [18:0] ev(
        input logic [2:0] st, input logic [2:0] alu, input logic srcb,
        input logic [1:0] ext, input logic irw, input logic pcw,
        input logic memw, input logic regw, input logic [1:0] pcs,
        input logic [1:0] dst, input logic [1:0] wds);
        return {st, alu, srcb, ext, irw, pcw, memw, regw, pcs, dst, wds};
    endfunction

    function automatic logic [18:0] observed();
        return {state, alu_op, alu_src_b, ext_op, ir_write, pc_write,
                mem_write, reg_write, pc_src, reg_dst, wd_sel};
    endfunction

    task automatic push(input string tag, input logic [18:0] v);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Compare one queued vector per cycle, advancing one clock after each.
    task automatic drain(input string name);
        int n;
        logic [18:0] got;
        exp_t e;
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = observed();
            check(e.tag, 32'(got), 32'(e.v));
            n++;
            @(posedge clk); #1;
        end
        $display("%0t %s: %0d cycles compared, failures so far=%0d", $time, name, n, failures);
    endtask

    localparam logic [18:0] V_FETCH = {3'd1, 3'b000, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    localparam logic [18:0] V_DEC   = {3'd2, 16'h0};

    task automatic instr(input string name, input logic [5:0] o, input logic [5:0] f, input logic z);
        op    = o;
        funct = f;
        zero  = z;
        push({name, "_F"}, V_FETCH);
    endtask

    // posedge-sampled count of mem_write high during the abort window
    logic mon_en = 1'b0;
    int   mem_hits = 0;
    always @(posedge clk) begin
        if (mon_en && mem_write) mem_hits++;
    end

    initial begin
        reset_n = 1'b0;
        op = 6'd0;
        funct = 6'd0;
        zero = 1'b0;
        #1;
        // Reset held for three cycles: everything zero, state S_RESET.
        for (int i = 0; i < 3; i++) push("rst", 19'h0);
        drain("reset");
        reset_n = 1'b1;
        push("rst_rel", 19'h0);
        drain("reset_release");

        // addu
        instr("addu", 6'h00, 6'h21, 1'b0);
        push("addu_D", V_DEC);
        push("addu_E", ev(3'd3, 3'b001, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        push("addu_W", ev(3'd5, 3'b000, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b01, 2'b00));
        drain("addu");

        // subu
        instr("subu", 6'h00, 6'h23, 1'b1);
        push("subu_D", V_DEC);
        push("subu_E", ev(3'd3, 3'b010, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        push("subu_W", ev(3'd5, 3'b000, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b01, 2'b00));
        drain("subu");

        // ori
        instr("ori", 6'h0D, 6'h3F, 1'b0);
        push("ori_D", V_DEC);
        push("ori_E", ev(3'd3, 3'b011, 1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        push("ori_W", ev(3'd5, 3'b000, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00));
        drain("ori");

        // lui: immediate operand, load-upper extension
        instr("lui", 6'h0F, 6'h00, 1'b0);
        push("lui_D", V_DEC);
        push("lui_E", ev(3'd3, 3'b011, 1, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        push("lui_W", ev(3'd5, 3'b000, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00));
        drain("lui");

        // lw: five cycles
        instr("lw", 6'h23, 6'h00, 1'b0);
        push("lw_D", V_DEC);
        push("lw_E", ev(3'd3, 3'b001, 1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        push("lw_M", ev(3'd4, 3'b000, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        push("lw_W", ev(3'd5, 3'b000, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01));
        drain("lw");

        // sw: mem_write only in MEM
        instr("sw", 6'h2B, 6'h00, 1'b0);
        push("sw_D", V_DEC);
        push("sw_E", ev(3'd3, 3'b001, 1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        push("sw_M", ev(3'd4, 3'b000, 0, 2'b00, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00));
        drain("sw");

        // beq taken / not taken
        instr("beq1", 6'h04, 6'h00, 1'b1);
        push("beq1_D", V_DEC);
        push("beq1_E", ev(3'd3, 3'b010, 0, 2'b00, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00));
        drain("beq_taken");
        instr("beq0", 6'h04, 6'h00, 1'b0);
        push("beq0_D", V_DEC);
        push("beq0_E", ev(3'd3, 3'b010, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00));
        drain("beq_not_taken");

        // j: two cycles
        instr("j", 6'h02, 6'h00, 1'b0);
        push("j_D", ev(3'd2, 3'b000, 0, 2'b00, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00));
        drain("j");

        // undefined op, nop, undefined funct
        instr("op3f", 6'h3F, 6'h21, 1'b1);
        push("op3f_D", V_DEC);
        drain("op_3f");
        instr("nop", 6'h00, 6'h00, 1'b0);
        push("nop_D", V_DEC);
        drain("nop");
        instr("fn3f", 6'h00, 6'h3F, 1'b0);
        push("fn3f_D", V_DEC);
        drain("funct_3f");

        // jal / jr: legal only with the jump feature
        instr("jal", 6'h03, 6'h00, 1'b0);
`ifdef MC_CTRL_JUMP_EN
        push("jal_D", ev(3'd2, 3'b000, 0, 2'b00, 0, 1, 0, 1, 2'b10, 2'b10, 2'b10));
`else
        push("jal_D", V_DEC);
`endif
        drain("jal");
        instr("jr", 6'h00, 6'h08, 1'b0);
`ifdef MC_CTRL_JUMP_EN
        push("jr_D", ev(3'd2, 3'b000, 0, 2'b00, 0, 1, 0, 0, 2'b11, 2'b00, 2'b00));
`else
        push("jr_D", V_DEC);
`endif
        drain("jr");

        // sw aborted by reset pulse during MEM
        instr("swab", 6'h2B, 6'h00, 1'b0);
        push("swab_D", V_DEC);
        push("swab_E", ev(3'd3, 3'b001, 1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        drain("sw_abort_pre");
        mon_en  = 1'b1;
        reset_n = 1'b0;
        #1;
        check("abort_state", 32'(state), 32'(S_RESET));
        check("abort_memw", 32'(mem_write), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        push("abort_rst", 19'h0);
        drain("sw_abort_reset");
        mon_en = 1'b0;
        check("abort_mem_hits", 32'(mem_hits), 32'd0);

        // Normal operation resumes after the abort
        instr("addu2", 6'h00, 6'h21, 1'b0);
        push("addu2_D", V_DEC);
        push("addu2_E", ev(3'd3, 3'b001, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        push("addu2_W", ev(3'd5, 3'b000, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b01, 2'b00));
        drain("addu_after_abort");
        check("final_state", 32'(state), 32'(S_FETCH));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameters: none; all encodings SHALL come from the shared package.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 op  input  6  IR[31:26], stable from DECODE until next FETCH.
REQ-005 funct  input  6  IR[5:0].
REQ-006 zero  input  1  equality flag from the datapath comparator (rs == rt).
REQ-007 alu_op  output  3  ALU select: 001 add, 010 sub, 011 or, 000 zero result.
REQ-008 alu_src_b  output  1  0 = rt register, 1 = extended immediate.
REQ-009 ext_op  output  2  00 zero-ext, 01 sign-ext, 10 load-upper (imm << 16).
REQ-010 ir_write, pc_write, mem_write, reg_write  output  1 each  write strobes.
REQ-011 pc_src  output  2  00 PC+4, 01 branch target, 10 jump target, 11 rs.
REQ-012 reg_dst  output  2  00 rt, 01 rd, 10 $31.
REQ-013 wd_sel  output  2  00 ALU result register, 01 memory data register, 10 PC+4.
REQ-014 state  output  3  current FSM state, debug only.

Function
REQ-015 FSM states SHALL be S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB.
REQ-016 S_FETCH: ir_write=1, pc_write=1, pc_src=00; next S_DECODE.
REQ-017 S_DECODE: j -> pc_write=1, pc_src=10, next S_FETCH; all other legal ops -> S_EXEC.
REQ-018 S_EXEC addu (op 000000, funct 100001): alu_op=001, alu_src_b=0; next S_WB.
REQ-019 S_EXEC subu (funct 100011): alu_op=010, alu_src_b=0; next S_WB.
REQ-020 S_EXEC ori (001101): alu_op=011, alu_src_b=1, ext_op=00; next S_WB.
REQ-021 S_EXEC lui (001111): alu_op=011 with rs forced to $0 by decode, ext_op=10; next S_WB.
REQ-022 S_EXEC lw (100011) / sw (101011): alu_op=001, alu_src_b=1, ext_op=01; next S_MEM.
REQ-023 S_EXEC beq (000100): alu_op=010; pc_write=zero, pc_src=01; next S_FETCH.
REQ-024 S_MEM: sw -> mem_write=1, next S_FETCH; lw -> next S_WB.
REQ-025 S_WB: reg_write=1; reg_dst=01 and wd_sel=00 for R-type, reg_dst=00 and wd_sel=00 for ori/lui, reg_dst=00 and wd_sel=01 for lw; next S_FETCH.
REQ-026 Latency in cycles incl. fetch: j 2, beq 3, sw 4, R-type/ori/lui 4, lw 5.
REQ-027 Undefined op or funct, including nop (all zero), SHALL act as a no-op: S_DECODE -> S_FETCH with no strobe asserted.
REQ-028 Outputs SHALL be Moore-style decodes of state, op and funct; strobes SHALL be 0 in every state/op pair not listed.
REQ-029 Non-strobe outputs not specified for a state SHALL be 0.

Reset
REQ-030 reset_n low SHALL force S_RESET immediately; all strobes 0, all selects 0.
REQ-031 S_RESET SHALL advance to S_FETCH on the first rising clk edge with reset_n high.
REQ-032 Reset mid-instruction SHALL abandon it; no partial write strobe may follow.

Configuration
REQ-033 Macro MC_CTRL_JUMP_EN: if defined, jal (000011) and jr (funct 001000) are legal.
REQ-034 With the macro, jal in S_DECODE SHALL assert reg_write=1, reg_dst=10, wd_sel=10, pc_write=1, pc_src=10, then go to S_FETCH; jr SHALL assert pc_write=1, pc_src=11, then go to S_FETCH.
REQ-035 Without the macro, jal and jr SHALL be handled as undefined per REQ-027.

Structure
REQ-036 Package mc_pkg SHALL hold the state enum, alu_op codes (ADD_OP=001, SUB_OP=010, ORR_OP=011), the opcode and funct constants, and the select encodings.
REQ-037 Sub-module mc_ctrl_decode SHALL hold the combinational op/funct-to-class decoder; the FSM SHALL stay in mc_ctrl.

Verification
REQ-038 reset_n low for 3 cycles, then high -> state S_RESET, then S_FETCH next edge; all strobes 0 during reset.
REQ-039 addu (op 0, funct 0x21) -> states F,D,E,WB; in E alu_op=001; in WB reg_write=1, reg_dst=01.
REQ-040 lw (op 0x23) -> 5 cycles; E alu_op=001, ext_op=01; WB wd_sel=01; sw (0x2B) -> mem_write=1 only in S_MEM.
REQ-041 beq (op 0x04) with zero=1 -> pc_write=1, pc_src=01 in E; with zero=0 -> pc_write=0; both return to FETCH after 3 cycles.
REQ-042 op 0x3F -> F,D,F, no strobe beyond fetch; jal with and without MC_CTRL_JUMP_EN -> reg_write=1 at $31 in D, versus no-op.
REQ-043 reset_n pulsed low during S_MEM of sw -> mem_write never asserted; FSM restarts at S_RESET.
